// File: rtl/regfile_2w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2w
// Purpose  : Two-write / two-read register file with optional write-to-read
//            forwarding and a pending-bit scoreboard with a population count.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2w #(
    parameter int W      = 32,
    parameter int N      = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [W-1:0]  qa,
    output logic [W-1:0]  qb,
    input  logic          we0,
    input  logic [AW-1:0] wn0,
    input  logic [W-1:0]  d0,
    input  logic          we1,
    input  logic [AW-1:0] wn1,
    input  logic [W-1:0]  d1,
    input  logic          iss,
    input  logic [AW-1:0] iss_rn,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   busy_cnt
);

    logic [W-1:0] r_regs [N];
    logic [N-1:0] r_pend;
    logic [AW:0]  r_cnt;

    logic [N-1:0] w_pend_nxt;
    logic [AW:0]  w_cnt_nxt;
    logic [W-1:0] w_qa_reg;
    logic [W-1:0] w_qb_reg;

    // Issue beats a same-cycle write so the newer producer stays outstanding.
    always_comb begin
        w_pend_nxt    = '0;
        w_cnt_nxt     = '0;
        for (int i = 1; i < N; i++) begin
            w_pend_nxt[i] = (iss && (iss_rn == AW'(i))) ||
                            (r_pend[i] && !((we0 && (wn0 == AW'(i))) ||
                                            (we1 && (wn1 == AW'(i)))));
        end
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[i]);
        end
    end

    // Entry 0 is only ever cleared, so it reads as zero permanently.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                if (we1 && (wn1 == AW'(i))) begin
                    r_regs[i] <= d1;
                end else if (we0 && (wn0 == AW'(i))) begin
                    r_regs[i] <= d0;
                end
            end
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_qa_reg = (rna == '0) ? '0 : r_regs[rna];
        w_qb_reg = (rnb == '0) ? '0 : r_regs[rnb];
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Forwarding is suppressed during reset since writes are ignored then.
            always_comb begin
                qa = w_qa_reg;
                if (!clr && (rna != '0)) begin
                    if (we1 && (wn1 == rna)) begin
                        qa = d1;
                    end else if (we0 && (wn0 == rna)) begin
                        qa = d0;
                    end
                end
            end
            always_comb begin
                qb = w_qb_reg;
                if (!clr && (rnb != '0)) begin
                    if (we1 && (wn1 == rnb)) begin
                        qb = d1;
                    end else if (we0 && (wn0 == rnb)) begin
                        qb = d0;
                    end
                end
            end
        end else begin : g_plain
            assign qa = w_qa_reg;
            assign qb = w_qb_reg;
        end
    endgenerate

    assign busy_a   = (rna != '0) && r_pend[rna];
    assign busy_b   = (rnb != '0) && r_pend[rnb];
    assign busy_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2w.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2w
// Purpose  : Directed self-checking bench for regfile_2w (forwarding and plain).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2w;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clr;
    logic [AW-1:0] rna, rnb, wn0, wn1, iss_rn;
    logic [W-1:0]  d0, d1;
    logic          we0, we1, iss;
    logic [W-1:0]  qa, qb, qa_nb, qb_nb;
    logic          busy_a, busy_b, busy_a_nb, busy_b_nb;
    logic [AW:0]   busy_cnt, busy_cnt_nb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_2w #(.W(W), .N(N), .AW(AW), .BYPASS(1)) dut (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .iss(iss), .iss_rn(iss_rn), .busy_a(busy_a), .busy_b(busy_b),
        .busy_cnt(busy_cnt)
    );

    regfile_2w #(.W(W), .N(N), .AW(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa_nb), .qb(qb_nb),
        .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
        .iss(iss), .iss_rn(iss_rn), .busy_a(busy_a_nb), .busy_b(busy_b_nb),
        .busy_cnt(busy_cnt_nb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
        wn0 = '0;   wn1 = '0;   iss_rn = '0;
        d0  = '0;   d1  = '0;
    endtask

    initial begin
        clr = 1'b1;
        rna = '0; rnb = '0;
        idle();
        #3;
        check("rst_qa", qa, 0);
        check("rst_cnt", busy_cnt, 0);
        cyc();
        clr = 1'b0;

        // Write reg5 and issue reg6, then reset asynchronously mid-cycle.
        we0 = 1'b1; wn0 = 5; d0 = 32'h1234; iss = 1'b1; iss_rn = 6;
        rna = 5; rnb = 6;
        cyc();
        idle();
        check("wr5_qa", qa, 32'h1234);
        check("iss6_cnt", busy_cnt, 1);
        check("iss6_busy_b", busy_b, 1);
        #2 clr = 1'b1;
        #1;
        check("async_qa", qa, 0);
        check("async_cnt", busy_cnt, 0);
        check("async_busy_b", busy_b, 0);
        we0 = 1'b1; wn0 = 5; d0 = 32'hFFFF; iss = 1'b1; iss_rn = 6;
        cyc();
        check("rst_hold_qa", qa, 0);
        check("rst_hold_cnt_nb", busy_cnt_nb, 0);
        idle();
        clr = 1'b0;
        cyc();
        check("post_rst_qa_nb", qa_nb, 0);
        check("post_rst_busy_b", busy_b, 0);

        // Same-cycle forwarding versus plain read.
        we0 = 1'b1; wn0 = 7; d0 = 32'hA5A5A5A5; rna = 7;
        #1;
        check("byp_qa", qa, 32'hA5A5A5A5);
        check("nb_qa_old", qa_nb, 0);
        cyc();
        idle();
        check("nb_qa_new", qa_nb, 32'hA5A5A5A5);

        // Collision on reg3: port 1 wins, both forwarded and stored.
        we0 = 1'b1; wn0 = 3; d0 = 32'h11; we1 = 1'b1; wn1 = 3; d1 = 32'h22;
        rna = 3; rnb = 7;
        #1;
        check("coll_byp_qa", qa, 32'h22);
        check("coll_qb", qb, 32'hA5A5A5A5);
        cyc();
        idle();
        check("coll_qa", qa, 32'h22);
        check("coll_qa_nb", qa_nb, 32'h22);
        we0 = 1'b1; wn0 = 0; d0 = 32'h11; we1 = 1'b1; wn1 = 0; d1 = 32'h22;
        rna = 0;
        #1;
        check("r0_byp_qa", qa, 0);
        cyc();
        idle();
        check("r0_qa", qa, 0);
        check("r0_qa_nb", qa_nb, 0);

        // Scoreboard on reg4.
        iss = 1'b1; iss_rn = 4; rna = 4;
        cyc();
        check("sb_cnt1", busy_cnt, 1);
        check("sb_busy_a", busy_a, 1);
        cyc();
        check("sb_reiss_cnt", busy_cnt, 1);
        we1 = 1'b1; wn1 = 4; d1 = 32'h44;
        cyc();
        idle();
        check("sb_race_busy", busy_a, 1);
        check("sb_race_cnt", busy_cnt, 1);
        check("sb_race_qa", qa, 32'h44);
        we0 = 1'b1; wn0 = 4; d0 = 32'h45;
        cyc();
        idle();
        check("sb_clear_busy", busy_a, 0);
        check("sb_clear_cnt", busy_cnt, 0);

        // Double clear in one cycle; write to non-pending register.
        iss = 1'b1; iss_rn = 8;
        cyc();
        iss_rn = 9;
        cyc();
        idle();
        check("dbl_cnt2", busy_cnt, 2);
        we0 = 1'b1; wn0 = 8; we1 = 1'b1; wn1 = 9;
        cyc();
        idle();
        check("dbl_cnt0", busy_cnt, 0);
        iss = 1'b1; iss_rn = 12;
        cyc();
        idle();
        we0 = 1'b1; wn0 = 13; d0 = 32'h13;
        cyc();
        idle();
        check("nonpend_wr_cnt", busy_cnt, 1);
        we0 = 1'b1; wn0 = 12;
        cyc();
        idle();

        // Saturation: every register pending, then issue to reg0.
        for (int i = 1; i < N; i++) begin
            iss = 1'b1; iss_rn = AW'(i);
            cyc();
        end
        idle();
        check("sat_cnt", busy_cnt, N - 1);
        iss = 1'b1; iss_rn = 0; rna = 31; rnb = 0;
        cyc();
        idle();
        check("sat_iss0_cnt", busy_cnt, N - 1);
        check("sat_busy_a", busy_a, 1);
        check("sat_busy_b0", busy_b, 0);
        check("sat_cnt_nb", busy_cnt_nb, N - 1);

        // Mid-operation reset clears pending state for good.
        #2 clr = 1'b1;
        #1;
        check("mid_rst_cnt", busy_cnt, 0);
        cyc();
        clr = 1'b0;
        cyc();
        check("mid_rst_after_cnt", busy_cnt, 0);
        check("mid_rst_busy_a", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
